// File: rtl/fifo_mc.sv
// fifo_mc: CHANNELS logical FIFOs sharing one RAM. Writes are steered by a channel tag and the
// output drains eligible channels round-robin, tagging each word with its channel index.
module fifo_mc #(
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 16,
    parameter int DIN       = 16,
    parameter int THRESHOLD = 0,
    parameter int REGOUT    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_din_valid,
    output logic                                 o_din_ready,
    input  logic [$clog2(CHANNELS)+DIN-1:0]      i_din_data,
    output logic                                 o_dout_valid,
    input  logic                                 i_dout_ready,
    output logic [$clog2(CHANNELS)+DIN-1:0]      o_dout_data,
    output logic [CHANNELS-1:0]                  o_full,
    output logic [CHANNELS-1:0]                  o_empty
);
    localparam int CHW = $clog2(CHANNELS);
    localparam int AW  = $clog2(DEPTH);
    localparam int DW  = CHW + DIN;
    localparam logic [AW+1:0] MIN_OCC = (AW+2)'((THRESHOLD > 1) ? THRESHOLD : 1);

    logic [DIN-1:0]      r_mem    [CHANNELS*DEPTH];
    logic [AW:0]         r_wrptr  [CHANNELS];
    logic [AW:0]         r_rdptr  [CHANNELS];
    logic [AW:0]         w_occ    [CHANNELS];
    logic [CHANNELS-1:0] w_elig;
    logic [CHW-1:0]      r_rr;
    logic [CHW-1:0]      w_wr_ch;
    logic [CHW-1:0]      w_arb;
    logic [CHW-1:0]      w_idx;
    logic [CHW-1:0]      w_sel;
    logic                w_wr_ok;
    logic                w_wr_en;
    logic                w_any;
    logic                w_pop;
    logic [DIN-1:0]      w_rd_word;

    assign w_wr_ch     = i_din_data[DW-1:DIN];
    assign w_wr_ok     = ({1'b0, w_wr_ch} < (CHW+1)'(CHANNELS));
    // Out-of-range channels are swallowed: always ready, never written.
    assign o_din_ready = w_wr_ok ? ~o_full[w_wr_ch] : 1'b1;
    assign w_wr_en     = i_din_valid & o_din_ready & w_wr_ok;
    assign w_rd_word   = r_mem[{w_sel, r_rdptr[w_sel][AW-1:0]}];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_occ[g]   = r_wrptr[g] - r_rdptr[g];
        assign o_empty[g] = (r_wrptr[g] == r_rdptr[g]);
        assign o_full[g]  = (r_wrptr[g][AW-1:0] == r_rdptr[g][AW-1:0]) &&
                            (r_wrptr[g][AW] != r_rdptr[g][AW]);
        assign w_elig[g]  = ~o_empty[g] && ({1'b0, w_occ[g]} >= MIN_OCC);
    end

    // Round-robin search from r_rr; scanning downward leaves the nearest eligible channel last.
    always_comb begin
        w_any = 1'b0;
        w_arb = {CHW{1'b0}};
        w_idx = {CHW{1'b0}};
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_idx = CHW'((int'(r_rr) + k) % CHANNELS);
            w_any = w_any | w_elig[w_idx];
            w_arb = w_elig[w_idx] ? w_idx : w_arb;
        end
    end

    // Shared RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[{w_wr_ch, r_wrptr[w_wr_ch][AW-1:0]}] <= i_din_data[DIN-1:0];
        end
    end

    // Per-channel pointers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= {CHW{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                r_wrptr[i] <= {(AW+1){1'b0}};
                r_rdptr[i] <= {(AW+1){1'b0}};
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wr_en && (w_wr_ch == CHW'(i))) begin
                    r_wrptr[i] <= r_wrptr[i] + (AW+1)'(1);
                end
                if (w_pop && (w_sel == CHW'(i))) begin
                    r_rdptr[i] <= r_rdptr[i] + (AW+1)'(1);
                end
            end
            if (w_pop) begin
                r_rr <= (w_sel == CHW'(CHANNELS - 1)) ? {CHW{1'b0}} : w_sel + CHW'(1);
            end
        end
    end

    if (REGOUT == 0) begin : g_direct
        logic           r_lock;
        logic [CHW-1:0] r_lock_ch;

        assign w_sel        = r_lock ? r_lock_ch : w_arb;
        assign o_dout_valid = r_lock | w_any;
        assign o_dout_data  = {w_sel, w_rd_word};
        assign w_pop        = o_dout_valid & i_dout_ready;

        // A stalled offer freezes the selected channel until it is accepted.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_lock    <= 1'b0;
                r_lock_ch <= {CHW{1'b0}};
            end else if (o_dout_valid && !i_dout_ready) begin
                r_lock    <= 1'b1;
                r_lock_ch <= w_sel;
            end else begin
                r_lock    <= 1'b0;
                r_lock_ch <= r_lock_ch;
            end
        end
    end else begin : g_reg
        logic          r_valid;
        logic [DW-1:0] r_data;

        assign w_sel        = w_arb;
        assign w_pop        = w_any & (~r_valid | i_dout_ready);
        assign o_dout_valid = r_valid;
        assign o_dout_data  = r_data;

        // Output register refills whenever it is empty or being consumed.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= {DW{1'b0}};
            end else if (w_pop) begin
                r_valid <= 1'b1;
                r_data  <= {w_sel, w_rd_word};
            end else if (!r_valid || i_dout_ready) begin
                r_valid <= 1'b0;
                r_data  <= r_data;
            end else begin
                r_valid <= r_valid;
                r_data  <= r_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_mc.sv
// Bench for fifo_mc: three instances (plain, registered output, threshold 3) checked against a
// queue-based channel model through per-instance scoreboards.
module tb_fifo_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        din_valid  [3];
    logic [17:0] din_data   [3];
    logic        dout_ready [3];
    logic        din_ready  [3];
    logic        dout_valid [3];
    logic [17:0] dout_data  [3];
    logic [3:0]  full       [3];
    logic [3:0]  empty      [3];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;
    int hs_cnt [3]  = '{0, 0, 0};
    logic [17:0] out_log [$];

    fifo_mc #(.CHANNELS(4), .DEPTH(4), .DIN(16), .THRESHOLD(0), .REGOUT(0)) u_plain (
        .clk(clk), .rst(rst), .i_din_valid(din_valid[0]), .o_din_ready(din_ready[0]),
        .i_din_data(din_data[0]), .o_dout_valid(dout_valid[0]), .i_dout_ready(dout_ready[0]),
        .o_dout_data(dout_data[0]), .o_full(full[0]), .o_empty(empty[0]));
    fifo_mc #(.CHANNELS(4), .DEPTH(4), .DIN(16), .THRESHOLD(0), .REGOUT(1)) u_regout (
        .clk(clk), .rst(rst), .i_din_valid(din_valid[1]), .o_din_ready(din_ready[1]),
        .i_din_data(din_data[1]), .o_dout_valid(dout_valid[1]), .i_dout_ready(dout_ready[1]),
        .o_dout_data(dout_data[1]), .o_full(full[1]), .o_empty(empty[1]));
    fifo_mc #(.CHANNELS(4), .DEPTH(4), .DIN(16), .THRESHOLD(3), .REGOUT(0)) u_thresh (
        .clk(clk), .rst(rst), .i_din_valid(din_valid[2]), .o_din_ready(din_ready[2]),
        .i_din_data(din_data[2]), .o_dout_valid(dout_valid[2]), .i_dout_ready(dout_ready[2]),
        .o_dout_data(dout_data[2]), .o_full(full[2]), .o_empty(empty[2]));

    // Reference model: per-channel queues plus round-robin/lock/output-register state.
    int          thr [3] = '{0, 0, 3};
    bit          rgo [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] mq  [3][4][$];
    logic [17:0] sbq [3][$];
    int          rr  [3] = '{0, 0, 0};
    bit          lk  [3] = '{1'b0, 1'b0, 1'b0};
    int          lkc [3] = '{0, 0, 0};
    bit          ov  [3] = '{1'b0, 1'b0, 1'b0};
    logic [17:0] od  [3] = '{18'h0, 18'h0, 18'h0};
    bit          e_valid [3];
    logic [17:0] e_data  [3];
    bit          e_rdy   [3];
    logic [3:0]  e_full  [3];
    logic [3:0]  e_empty [3];

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Model advances one clock per falling edge, using the inputs that the next rising edge samples.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int mino, sel, wch, c;
            bit any, wr;
            logic [15:0] w;
            mino = (thr[d] > 1) ? thr[d] : 1;
            any  = 1'b0;
            sel  = 0;
            for (int k = 3; k >= 0; k--) begin
                c = (rr[d] + k) % 4;
                if (mq[d][c].size() >= mino) begin
                    any = 1'b1;
                    sel = c;
                end
            end
            for (int j = 0; j < 4; j++) begin
                e_full[d][j]  = (mq[d][j].size() == 4);
                e_empty[d][j] = (mq[d][j].size() == 0);
            end
            wch      = int'(din_data[d][17:16]);
            e_rdy[d] = (mq[d][wch].size() < 4);
            wr       = din_valid[d] && e_rdy[d];
            if (!rgo[d]) begin
                if (lk[d]) begin
                    any = 1'b1;
                    sel = lkc[d];
                end
                e_valid[d] = any;
                e_data[d]  = any ? {2'(sel), mq[d][sel][0]} : 18'h0;
                if (any && dout_ready[d]) begin
                    w = mq[d][sel].pop_front();
                    sbq[d].push_back({2'(sel), w});
                    rr[d] = (sel + 1) % 4;
                    lk[d] = 1'b0;
                end else if (any) begin
                    lk[d]  = 1'b1;
                    lkc[d] = sel;
                end else begin
                    lk[d] = 1'b0;
                end
            end else begin
                e_valid[d] = ov[d];
                e_data[d]  = od[d];
                if (ov[d] && dout_ready[d]) sbq[d].push_back(od[d]);
                if (!ov[d] || dout_ready[d]) begin
                    if (any) begin
                        w     = mq[d][sel].pop_front();
                        od[d] = {2'(sel), w};
                        ov[d] = 1'b1;
                        rr[d] = (sel + 1) % 4;
                    end else begin
                        ov[d] = 1'b0;
                    end
                end
            end
            if (wr) mq[d][wch].push_back(din_data[d][15:0]);
            if (rst) begin
                for (int j = 0; j < 4; j++) mq[d][j].delete();
                rr[d] = 0;
                lk[d] = 1'b0;
                ov[d] = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs against the model and drains the scoreboards on handshakes.
    always @(negedge clk) begin
        logic [17:0] exp_w;
        #1;
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk("dout_valid", d, dout_valid[d], e_valid[d]);
                if (e_valid[d]) chk("dout_data", d, dout_data[d], e_data[d]);
                chk("din_ready", d, din_ready[d], e_rdy[d]);
                chk("full", d, full[d], e_full[d]);
                chk("empty", d, empty[d], e_empty[d]);
                if (dout_valid[d] === 1'b1 && dout_ready[d]) begin
                    hs_cnt[d]++;
                    if (d == 0) out_log.push_back(dout_data[d]);
                    if (sbq[d].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL scoreboard dut%0d: got word %0h expected none", d, dout_data[d]);
                    end else begin
                        exp_w = sbq[d].pop_front();
                        chk("sb_word", d, dout_data[d], exp_w);
                    end
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(int d, int ch, logic [15:0] p);
        din_data[d]  = {2'(ch), p};
        din_valid[d] = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (din_ready[d] === 1'b1) begin
                @(posedge clk);
                #1;
                din_valid[d] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL put_timeout dut%0d: got no ready in 100 cycles expected ready for ch%0d", d, ch);
        din_valid[d] = 1'b0;
    endtask

    initial begin
        int h0;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            din_valid[d]  = 1'b0;
            din_data[d]   = 18'h0;
            dout_ready[d] = 1'b0;
        end
        cyc(2);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Random traffic on all three instances.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 3; d++) begin
                din_valid[d]  = 1'($urandom_range(0, 1));
                din_data[d]   = {2'($urandom_range(0, 3)), 16'($urandom)};
                dout_ready[d] = ($urandom_range(0, 3) != 0);
            end
            cyc(1);
        end
        for (int d = 0; d < 3; d++) begin
            din_valid[d]  = 1'b0;
            dout_ready[d] = 1'b1;
        end
        cyc(40);

        // Reset with three words parked in ch0.
        dout_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) put(0, 0, 16'(16'h6000 + i));
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk); #2;
        chk("t6_valid", 0, dout_valid[0], 1'b0);
        chk("t6_empty", 0, empty[0], 4'hf);
        cyc(1);
        out_log.delete();
        dout_ready[0] = 1'b1;
        put(0, 0, 16'h6006);
        cyc(3);
        chk("t6_count", 0, out_log.size(), 1);
        chk("t6_word", 0, (out_log.size() > 0) ? out_log[0] : 18'h0, {2'd0, 16'h6006});

        // One word per channel, drained in channel order.
        out_log.delete();
        for (int ch = 0; ch < 4; ch++) put(0, ch, 16'(16'hA0 + ch));
        cyc(3);
        chk("t1_count", 0, out_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t1_order", 0, (i < out_log.size()) ? out_log[i] : 18'h0, {2'(i), 16'(16'hA0 + i)});

        // Fill ch2, probe ready per channel, then stall a fifth write until one pop.
        dout_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) put(0, 2, 16'(16'h2200 + i));
        din_data[0] = {2'd2, 16'h0};
        @(negedge clk); #2;
        chk("t2_full2", 0, full[0][2], 1'b1);
        chk("t2_rdy_ch2", 0, din_ready[0], 1'b0);
        cyc(1);
        din_data[0] = {2'd1, 16'h0};
        @(negedge clk); #2;
        chk("t2_rdy_ch1", 0, din_ready[0], 1'b1);
        cyc(1);
        fork
            put(0, 2, 16'h2204);
            begin
                cyc(3);
                dout_ready[0] = 1'b1;
                cyc(1);
                dout_ready[0] = 1'b0;
            end
        join
        dout_ready[0] = 1'b1;
        cyc(8);

        // Stalled ch1 offer must not move while ch0 arrives behind it.
        dout_ready[0] = 1'b0;
        put(0, 1, 16'h3101);
        put(0, 0, 16'h3000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("t3_hold", 0, dout_data[0], {2'd1, 16'h3101});
        end
        cyc(1);
        out_log.delete();
        dout_ready[0] = 1'b1;
        cyc(4);
        chk("t3_first", 0, (out_log.size() > 0) ? out_log[0] : 18'h0, {2'd1, 16'h3101});
        chk("t3_second", 0, (out_log.size() > 1) ? out_log[1] : 18'h0, {2'd0, 16'h3000});

        // Registered output: 32-word round-robin stream with a one-cycle ready drop.
        dout_ready[1] = 1'b1;
        h0 = hs_cnt[1];
        fork
            for (int i = 0; i < 32; i++) put(1, i % 4, 16'(16'h5000 + i));
            begin
                cyc(16);
                dout_ready[1] = 1'b0;
                cyc(1);
                dout_ready[1] = 1'b1;
            end
        join
        cyc(6);
        chk("t5_count", 1, hs_cnt[1] - h0, 32);

        // Threshold 3: nothing leaves ch3 until it holds three words.
        dout_ready[2] = 1'b1;
        h0 = hs_cnt[2];
        put(2, 3, 16'h4000);
        put(2, 3, 16'h4001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            chk("t4_below", 2, dout_valid[2], 1'b0);
        end
        cyc(1);
        put(2, 3, 16'h4002);
        @(negedge clk); #2;
        chk("t4_valid", 2, dout_valid[2], 1'b1);
        chk("t4_first", 2, dout_data[2], {2'd3, 16'h4000});
        cyc(1);
        put(2, 3, 16'h4003);
        put(2, 3, 16'h4004);
        cyc(6);
        chk("t4_count", 2, hs_cnt[2] - h0, 3);

        for (int d = 0; d < 3; d++)
            chk("sb_leftover", d, sbq[d].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
